// File: rtl/event_encoder_8to3.sv
// Queues single-cycle event pulses and emits one 3-bit event code per valid/ready transfer.
// 1-cycle latency In->Out; Out/Valid hold while Ready=0, new events keep accumulating in Pend.
module event_encoder_8to3 #(
   parameter bit RR = 1'b0
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [7:0] In,
   input  logic       Ready,
   input  logic       ClrDrop,
   output logic [2:0] Out,
   output logic       Valid,
   output logic       Busy,
   output logic       Dropped
);

   logic [7:0] pend;
   logic [7:0] cand;
   logic [2:0] last;
   logic [2:0] sel;
   logic [2:0] idx;
   logic       found;
   logic       load;

   assign cand = pend | In;
   assign load = ~Valid | Ready;
   assign Busy = Valid | (|pend);

   always_comb begin
      sel   = 3'd0;
      found = 1'b0;
      idx   = 3'd0;
      if (RR == 1'b0) begin
         for (int i = 0; i < 8; i++) begin
            if (!found && cand[i]) begin
               sel   = 3'(i);
               found = 1'b1;
            end
         end
      end else begin
         // Scan starts one past the last grant; k=8 wraps back onto last itself.
         for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!found && cand[idx]) begin
               sel   = idx;
               found = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Out     <= 3'd0;
         Valid   <= 1'b0;
         Dropped <= 1'b0;
         pend    <= 8'd0;
         last    <= 3'd7;
      end else begin
         // A fresh drop outranks a simultaneous clear.
         Dropped <= (|(In & pend)) | (Dropped & ~ClrDrop);
         if (load) begin
            if (found) begin
               Out   <= sel;
               Valid <= 1'b1;
               pend  <= cand & ~(8'b1 << sel);
               last  <= sel;
            end else begin
               Valid <= 1'b0;
               pend  <= 8'd0;
            end
         end else begin
            pend <= cand;
         end
      end
   end

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Checks fixed-priority and round-robin encoders against an in-bench event queue model.
module tb_event_encoder_8to3;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_ev;
   logic       ready;
   logic       clr_drop;
   logic [2:0] dout   [2];
   logic       dvalid [2];
   logic       dbusy  [2];
   logic       ddrop  [2];

   int n_checks = 0;
   int n_fail   = 0;

   bit [7:0] mpend  [2];
   int       mlast  [2];
   int       mout   [2];
   bit       mvalid [2];
   bit       mdrop  [2];

   event_encoder_8to3 #(.RR(1'b0)) dut_fp (
      .Clk(clk), .Rst_n(rst_n), .In(in_ev), .Ready(ready), .ClrDrop(clr_drop),
      .Out(dout[0]), .Valid(dvalid[0]), .Busy(dbusy[0]), .Dropped(ddrop[0])
   );

   event_encoder_8to3 #(.RR(1'b1)) dut_rr (
      .Clk(clk), .Rst_n(rst_n), .In(in_ev), .Ready(ready), .ClrDrop(clr_drop),
      .Out(dout[1]), .Valid(dvalid[1]), .Busy(dbusy[1]), .Dropped(ddrop[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mpend[m]  = 8'd0;
         mlast[m]  = 7;
         mout[m]   = 0;
         mvalid[m] = 1'b0;
         mdrop[m]  = 1'b0;
      end
   endtask

   // One clock edge of the event queue: merge arrivals, grant one if the slot frees up.
   task automatic model_edge();
      if (rst_n) begin
         for (int m = 0; m < 2; m++) begin
            bit [7:0] cand;
            bit       drop;
            int       sel;
            cand = mpend[m] | in_ev;
            drop = (in_ev & mpend[m]) != 8'd0;
            sel  = -1;
            if (!mvalid[m] || ready) begin
               for (int off = 0; off < 8; off++) begin
                  int pos;
                  pos = (m == 0) ? off : (mlast[m] + 1 + off) % 8;
                  if (sel < 0 && cand[pos]) sel = pos;
               end
               if (sel >= 0) begin
                  mout[m]   = sel;
                  mvalid[m] = 1'b1;
                  cand[sel] = 1'b0;
                  mpend[m]  = cand;
                  mlast[m]  = sel;
               end else begin
                  mvalid[m] = 1'b0;
                  mpend[m]  = 8'd0;
               end
            end else begin
               mpend[m] = cand;
            end
            if (drop) mdrop[m] = 1'b1;
            else if (clr_drop) mdrop[m] = 1'b0;
         end
      end
   endtask

   task automatic compare_all();
      for (int m = 0; m < 2; m++) begin
         chk(m == 0 ? "fp_out"   : "rr_out",   int'(dout[m]),   mout[m]);
         chk(m == 0 ? "fp_valid" : "rr_valid", int'(dvalid[m]), int'(mvalid[m]));
         chk(m == 0 ? "fp_busy"  : "rr_busy",  int'(dbusy[m]),  int'(mvalid[m] || mpend[m] != 8'd0));
         chk(m == 0 ? "fp_drop"  : "rr_drop",  int'(ddrop[m]),  int'(mdrop[m]));
      end
   endtask

   // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
   task automatic cycle(input logic [7:0] i, input logic r, input logic c);
      in_ev    = i;
      ready    = r;
      clr_drop = c;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_ev    = 8'd0;
      ready    = 1'b0;
      clr_drop = 1'b0;
      model_reset();
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_ev    = 8'd0;
      ready    = 1'b0;
      clr_drop = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();
      chk("reset_valid", int'(dvalid[0]), 0);
      chk("reset_out",   int'(dout[0]),   0);
      chk("reset_busy",  int'(dbusy[0]),  0);
      chk("reset_drop",  int'(ddrop[0]),  0);

      // Single event
      cycle(8'h20, 1'b1, 1'b0);
      chk("single_out",    int'(dout[0]),   5);
      chk("single_valid",  int'(dvalid[0]), 1);
      chk("single_rr_out", int'(dout[1]),   5);
      cycle(8'h00, 1'b1, 1'b0);
      chk("single_idle_valid", int'(dvalid[0]), 0);
      chk("single_idle_busy",  int'(dbusy[0]),  0);

      // Burst, fixed priority
      do_reset();
      cycle(8'h96, 1'b1, 1'b0);
      chk("burst_out0", int'(dout[0]), 1);
      cycle(8'h00, 1'b1, 1'b0);
      chk("burst_out1", int'(dout[0]), 2);
      cycle(8'h00, 1'b1, 1'b0);
      chk("burst_out2", int'(dout[0]), 4);
      cycle(8'h00, 1'b1, 1'b0);
      chk("burst_out3", int'(dout[0]), 7);
      chk("burst_drop", int'(ddrop[0]), 0);
      cycle(8'h00, 1'b1, 1'b0);
      chk("burst_done_valid", int'(dvalid[0]), 0);

      // Backpressure, with a repeat of the code being held
      do_reset();
      cycle(8'h01, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle((k == 2) ? 8'h01 : 8'h00, 1'b0, 1'b0);
         chk("stall_out",   int'(dout[0]),   0);
         chk("stall_valid", int'(dvalid[0]), 1);
      end
      chk("stall_drop", int'(ddrop[0]), 0);
      chk("stall_busy", int'(dbusy[0]), 1);
      cycle(8'h00, 1'b1, 1'b0);
      chk("stall_rel_out",   int'(dout[0]),   0);
      chk("stall_rel_valid", int'(dvalid[0]), 1);
      cycle(8'h00, 1'b1, 1'b0);
      chk("stall_end_valid", int'(dvalid[0]), 0);

      // Drop and clear
      do_reset();
      cycle(8'h01, 1'b0, 1'b0);
      cycle(8'h08, 1'b0, 1'b0);
      chk("drop_first", int'(ddrop[0]), 0);
      cycle(8'h08, 1'b0, 1'b0);
      chk("drop_set", int'(ddrop[0]), 1);
      cycle(8'h00, 1'b0, 1'b0);
      chk("drop_sticky", int'(ddrop[0]), 1);
      cycle(8'h00, 1'b0, 1'b1);
      chk("drop_clear", int'(ddrop[0]), 0);
      cycle(8'h08, 1'b0, 1'b1);
      chk("drop_beats_clear", int'(ddrop[0]), 1);
      cycle(8'h00, 1'b1, 1'b1);
      chk("drop_clear2", int'(ddrop[0]), 0);
      for (int k = 0; k < 3; k++) cycle(8'h00, 1'b1, 1'b0);

      // Round-robin versus fixed priority on a held request pair
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cycle(8'h81, 1'b1, 1'b0);
         chk("rr_alt_out", int'(dout[1]), (k % 2 == 1) ? 7 : 0);
         chk("fp_hold_out", int'(dout[0]), 0);
      end
      chk("fp_starved_busy", int'(dbusy[0]), 1);
      for (int k = 0; k < 3; k++) cycle(8'h00, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a burst
      do_reset();
      cycle(8'hFF, 1'b0, 1'b0);
      chk("midrst_pre_valid", int'(dvalid[0]), 1);
      rst_n = 1'b0;
      in_ev = 8'h00;
      model_reset();
      #1;
      chk("midrst_valid",   int'(dvalid[0]), 0);
      chk("midrst_out",     int'(dout[0]),   0);
      chk("midrst_busy",    int'(dbusy[0]),  0);
      chk("midrst_rr_busy", int'(dbusy[1]),  0);
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      cycle(8'h00, 1'b1, 1'b0);
      chk("midrst_after_valid",    int'(dvalid[0]), 0);
      chk("midrst_after_rr_valid", int'(dvalid[1]), 0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] ev;
         int         kind;
         if ($urandom_range(0, 599) == 0) do_reset();
         kind = $urandom_range(0, 3);
         case (kind)
            0:       ev = 8'h00;
            1:       ev = 8'h01 << $urandom_range(0, 7);
            2:       ev = 8'($urandom);
            default: ev = 8'($urandom) & 8'($urandom);
         endcase
         cycle(ev, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
